// File: rtl/planificador_ascensor_pkg.sv
// Shared definitions for the four-floor elevator scheduler: state encoding,
// floor count, travel directions and request-mask helpers.
package planificador_ascensor_pkg;

    localparam int NUM_PISOS = 4;

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] SUBIENDO = 2'd1;
    localparam logic [1:0] BAJANDO  = 2'd2;
    localparam logic [1:0] PUERTA   = 2'd3;

    localparam logic DIR_SUBIR = 1'b1;
    localparam logic DIR_BAJAR = 1'b0;

    // Floors strictly above piso; the shift overflows to zero at the top floor.
    function automatic logic [NUM_PISOS-1:0] mascara_arriba(input logic [1:0] piso);
        return ~((4'd2 << piso) - 4'd1);
    endfunction

    function automatic logic [NUM_PISOS-1:0] mascara_abajo(input logic [1:0] piso);
        return (4'd1 << piso) - 4'd1;
    endfunction

endpackage

// File: rtl/planificador_ascensor_temporizador.sv
// Loadable down-counter shared by travel and door timing; ultimo_o flags that
// the next enabled decrement is the one that expires the count.
module temporizador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         carga_i,
    input  logic [W-1:0] valor_i,
    input  logic         en_i,
    output logic         ultimo_o
);

    logic [W-1:0] cuenta_q;
    logic [W-1:0] cuenta_d;

    // Next count: a load wins over a decrement; the count rests at zero.
    always_comb begin
        cuenta_d = cuenta_q;
        if (carga_i) begin
            cuenta_d = valor_i;
        end else if (en_i && (cuenta_q != {W{1'b0}})) begin
            cuenta_d = cuenta_q - W'(1);
        end else begin
            cuenta_d = cuenta_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta_q <= {W{1'b0}};
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign ultimo_o = (cuenta_q == W'(1));

endmodule

// File: rtl/planificador_ascensor.sv
// Four-floor elevator scheduler: latches floor requests, chooses a travel
// direction with preference for the last one, times travel and door opening.
module planificador_ascensor
    import planificador_ascensor_pkg::*;
#(
    parameter int unsigned T_VIAJE  = 50_000_000,
    parameter int unsigned T_PUERTA = 150_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PISOS-1:0] boton,
    input  logic                 parada,
    output logic [1:0]           piso,
    output logic [NUM_PISOS-1:0] pendientes,
    output logic                 motor_subir,
    output logic                 motor_bajar,
    output logic                 puerta_abierta,
    output logic [1:0]           estado
);

    localparam int unsigned T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int          TW    = $clog2(T_MAX + 1);

    logic [1:0]           estado_q, estado_d;
    logic [1:0]           piso_q, piso_d;
    logic [NUM_PISOS-1:0] pendientes_q, pendientes_d;
    logic                 dir_q, dir_d;

    logic                 carga_s;
    logic [TW-1:0]        valor_s;
    logic                 en_s;
    logic                 ultimo_s;
    logic                 hay_arriba_s;
    logic                 hay_abajo_s;
    logic [1:0]           piso_sig_s;
    logic [1:0]           piso_ant_s;

    assign hay_arriba_s = |(pendientes_q & mascara_arriba(piso_q));
    assign hay_abajo_s  = |(pendientes_q & mascara_abajo(piso_q));
    assign piso_sig_s   = piso_q + 2'd1;
    assign piso_ant_s   = piso_q - 2'd1;

    temporizador #(
        .W (TW)
    ) u_temporizador (
        .clk      (clk),
        .rst      (reset),
        .carga_i  (carga_s),
        .valor_i  (valor_s),
        .en_i     (en_s),
        .ultimo_o (ultimo_s)
    );

    // Next-state, request latching and timer control; parada freezes all but requests.
    always_comb begin
        estado_d     = estado_q;
        piso_d       = piso_q;
        dir_d        = dir_q;
        pendientes_d = pendientes_q | boton;
        carga_s      = 1'b0;
        valor_s      = TW'(T_VIAJE);
        en_s         = 1'b0;
        if (!parada) begin
            case (estado_q)
                REPOSO: begin
                    if (pendientes_q[piso_q]) begin
                        estado_d = PUERTA;
                        carga_s  = 1'b1;
                        valor_s  = TW'(T_PUERTA);
                    end else if (hay_arriba_s && ((dir_q == DIR_SUBIR) || !hay_abajo_s)) begin
                        estado_d = SUBIENDO;
                        dir_d    = DIR_SUBIR;
                        carga_s  = 1'b1;
                    end else if (hay_abajo_s) begin
                        estado_d = BAJANDO;
                        dir_d    = DIR_BAJAR;
                        carga_s  = 1'b1;
                    end else begin
                        estado_d = REPOSO;
                    end
                end
                SUBIENDO: begin
                    en_s = 1'b1;
                    if (ultimo_s) begin
                        if (piso_q != 2'd3) begin
                            piso_d = piso_sig_s;
                            if (pendientes_q[piso_sig_s]) begin
                                estado_d = PUERTA;
                                carga_s  = 1'b1;
                                valor_s  = TW'(T_PUERTA);
                            end else if (piso_sig_s == 2'd3) begin
                                estado_d = REPOSO;
                            end else begin
                                carga_s = 1'b1;
                            end
                        end else begin
                            estado_d = REPOSO;
                        end
                    end else begin
                        estado_d = SUBIENDO;
                    end
                end
                BAJANDO: begin
                    en_s = 1'b1;
                    if (ultimo_s) begin
                        if (piso_q != 2'd0) begin
                            piso_d = piso_ant_s;
                            if (pendientes_q[piso_ant_s]) begin
                                estado_d = PUERTA;
                                carga_s  = 1'b1;
                                valor_s  = TW'(T_PUERTA);
                            end else if (piso_ant_s == 2'd0) begin
                                estado_d = REPOSO;
                            end else begin
                                carga_s = 1'b1;
                            end
                        end else begin
                            estado_d = REPOSO;
                        end
                    end else begin
                        estado_d = BAJANDO;
                    end
                end
                PUERTA: begin
                    // A press at the open floor is served by keeping the door open longer.
                    pendientes_d[piso_q] = 1'b0;
                    if (boton[piso_q]) begin
                        carga_s = 1'b1;
                        valor_s = TW'(T_PUERTA);
                    end else begin
                        en_s = 1'b1;
                        if (ultimo_s) begin
                            estado_d = REPOSO;
                        end else begin
                            estado_d = PUERTA;
                        end
                    end
                end
                default: begin
                    estado_d = REPOSO;
                end
            endcase
        end else begin
            estado_d = estado_q;
        end
    end

    // State, floor, pending-request and direction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q     <= REPOSO;
            piso_q       <= 2'd0;
            pendientes_q <= {NUM_PISOS{1'b0}};
            dir_q        <= DIR_SUBIR;
        end else begin
            estado_q     <= estado_d;
            piso_q       <= piso_d;
            pendientes_q <= pendientes_d;
            dir_q        <= dir_d;
        end
    end

    assign estado         = estado_q;
    assign piso           = piso_q;
    assign pendientes     = pendientes_q;
    assign puerta_abierta = (estado_q == PUERTA);
    assign motor_subir    = (estado_q == SUBIENDO) && !parada;
    assign motor_bajar    = (estado_q == BAJANDO) && !parada;

endmodule

// File: tb/tb_planificador_ascensor.sv
// Scenario bench for planificador_ascensor with T_VIAJE=4, T_PUERTA=3:
// expected outputs are queued per cycle and compared as the run reaches them.
module tb_planificador_ascensor;

    localparam logic [1:0] E_REP = 2'd0;
    localparam logic [1:0] E_SUB = 2'd1;
    localparam logic [1:0] E_BAJ = 2'd2;
    localparam logic [1:0] E_PTA = 2'd3;
    localparam logic [2:0] A_NADA = 3'b000;
    localparam logic [2:0] A_SUB  = 3'b100;
    localparam logic [2:0] A_BAJ  = 3'b010;
    localparam logic [2:0] A_PTA  = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] boton;
    logic       parada;
    logic [1:0] piso;
    logic [3:0] pendientes;
    logic       motor_subir;
    logic       motor_bajar;
    logic       puerta_abierta;
    logic [1:0] estado;
    logic [10:0] salidas;

    typedef struct {
        int          ciclo;
        logic [10:0] valor;
        string       tag;
    } esp_t;

    esp_t sb[$];
    int   ciclo = 0;
    int   total = 0;
    int   bad   = 0;

    planificador_ascensor #(
        .T_VIAJE  (4),
        .T_PUERTA (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .boton          (boton),
        .parada         (parada),
        .piso           (piso),
        .pendientes     (pendientes),
        .motor_subir    (motor_subir),
        .motor_bajar    (motor_bajar),
        .puerta_abierta (puerta_abierta),
        .estado         (estado)
    );

    always #5 clk = ~clk;

    assign salidas = {estado, piso, pendientes, motor_subir, motor_bajar, puerta_abierta};

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, req);
        end
    endtask

    task automatic esp(input string tag, input int c, input logic [1:0] e, input logic [1:0] p,
                       input logic [3:0] pd, input logic [2:0] act);
        esp_t x;
        x.ciclo = c;
        x.valor = {e, p, pd, act};
        x.tag   = tag;
        sb.push_back(x);
    endtask

    task automatic verificar();
        esp_t x;
        while (sb.size() > 0 && sb[0].ciclo <= ciclo) begin
            x = sb.pop_front();
            comprobar($sformatf("%s@%0d", x.tag, x.ciclo), {21'd0, salidas}, {21'd0, x.valor});
        end
    endtask

    task automatic paso(input logic [3:0] b, input logic p);
        boton  = b;
        parada = p;
        @(posedge clk);
        #1;
        ciclo++;
        verificar();
    endtask

    task automatic correr(input int n, input logic p);
        for (int i = 0; i < n; i++) begin
            paso(4'b0000, p);
        end
    endtask

    task automatic cerrar(input string tag);
        comprobar({tag, "_cola"}, sb.size(), 32'd0);
        sb.delete();
        ciclo = 0;
    endtask

    task automatic reiniciar(input string tag);
        reset  = 1'b1;
        boton  = 4'b0000;
        parada = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        comprobar(tag, {21'd0, salidas}, 32'd0);
        reset = 1'b0;
        ciclo = 0;
    endtask

    initial begin
        reiniciar("reset_ini");

        // Travel from 0 to 2, door, back to idle.
        esp("a_latch", 1, E_REP, 2'd0, 4'b0100, A_NADA);
        esp("a_sube", 2, E_SUB, 2'd0, 4'b0100, A_SUB);
        esp("a_p0fin", 5, E_SUB, 2'd0, 4'b0100, A_SUB);
        esp("a_p1", 6, E_SUB, 2'd1, 4'b0100, A_SUB);
        esp("a_p1fin", 9, E_SUB, 2'd1, 4'b0100, A_SUB);
        esp("a_pta1", 10, E_PTA, 2'd2, 4'b0100, A_PTA);
        esp("a_pta2", 11, E_PTA, 2'd2, 4'b0000, A_PTA);
        esp("a_pta3", 12, E_PTA, 2'd2, 4'b0000, A_PTA);
        esp("a_rep", 13, E_REP, 2'd2, 4'b0000, A_NADA);
        paso(4'b0100, 1'b0);
        correr(12, 1'b0);
        cerrar("a");

        // Request at the current floor: door only.
        reiniciar("reset_b");
        esp("b_latch", 1, E_REP, 2'd0, 4'b0001, A_NADA);
        esp("b_pta1", 2, E_PTA, 2'd0, 4'b0001, A_PTA);
        esp("b_pta2", 3, E_PTA, 2'd0, 4'b0000, A_PTA);
        esp("b_pta3", 4, E_PTA, 2'd0, 4'b0000, A_PTA);
        esp("b_rep", 5, E_REP, 2'd0, 4'b0000, A_NADA);
        paso(4'b0001, 1'b0);
        correr(4, 1'b0);
        cerrar("b");

        // Up to 1, then 3 and 0 together: last direction (up) wins.
        esp("c_pta1", 6, E_PTA, 2'd1, 4'b0010, A_PTA);
        esp("c_rep1", 9, E_REP, 2'd1, 4'b0000, A_NADA);
        esp("c_latch", 10, E_REP, 2'd1, 4'b1001, A_NADA);
        esp("c_sube", 11, E_SUB, 2'd1, 4'b1001, A_SUB);
        esp("c_p2", 15, E_SUB, 2'd2, 4'b1001, A_SUB);
        esp("c_pta3", 19, E_PTA, 2'd3, 4'b1001, A_PTA);
        esp("c_clr3", 20, E_PTA, 2'd3, 4'b0001, A_PTA);
        esp("c_rep3", 22, E_REP, 2'd3, 4'b0001, A_NADA);
        esp("c_baja", 23, E_BAJ, 2'd3, 4'b0001, A_BAJ);
        esp("c_p2b", 27, E_BAJ, 2'd2, 4'b0001, A_BAJ);
        esp("c_p1b", 31, E_BAJ, 2'd1, 4'b0001, A_BAJ);
        esp("c_pta0", 35, E_PTA, 2'd0, 4'b0001, A_PTA);
        esp("c_clr0", 36, E_PTA, 2'd0, 4'b0000, A_PTA);
        esp("c_rep0", 38, E_REP, 2'd0, 4'b0000, A_NADA);
        paso(4'b0010, 1'b0);
        correr(8, 1'b0);
        paso(4'b1001, 1'b0);
        correr(28, 1'b0);
        cerrar("c");

        // Press at the open floor on the second door cycle reloads the door timer.
        esp("d_pta1", 10, E_PTA, 2'd2, 4'b0100, A_PTA);
        esp("d_pta2", 11, E_PTA, 2'd2, 4'b0000, A_PTA);
        esp("d_recarga", 12, E_PTA, 2'd2, 4'b0000, A_PTA);
        esp("d_extra2", 13, E_PTA, 2'd2, 4'b0000, A_PTA);
        esp("d_extra3", 14, E_PTA, 2'd2, 4'b0000, A_PTA);
        esp("d_rep", 15, E_REP, 2'd2, 4'b0000, A_NADA);
        paso(4'b0100, 1'b0);
        correr(10, 1'b0);
        paso(4'b0100, 1'b0);
        correr(3, 1'b0);
        cerrar("d");

        // Emergency stop mid-travel, with a press latched during the stop.
        esp("e_baja", 2, E_BAJ, 2'd2, 4'b0001, A_BAJ);
        esp("e_pre", 4, E_BAJ, 2'd2, 4'b0001, A_BAJ);
        esp("e_stop", 5, E_BAJ, 2'd2, 4'b0001, A_NADA);
        esp("e_latch", 7, E_BAJ, 2'd2, 4'b1001, A_NADA);
        esp("e_stopfin", 14, E_BAJ, 2'd2, 4'b1001, A_NADA);
        esp("e_sigue", 15, E_BAJ, 2'd2, 4'b1001, A_BAJ);
        esp("e_p1", 16, E_BAJ, 2'd1, 4'b1001, A_BAJ);
        esp("e_pta0", 20, E_PTA, 2'd0, 4'b1001, A_PTA);
        esp("e_clr0", 21, E_PTA, 2'd0, 4'b1000, A_PTA);
        esp("e_rep", 23, E_REP, 2'd0, 4'b1000, A_NADA);
        esp("f_sube", 24, E_SUB, 2'd0, 4'b1000, A_SUB);
        esp("f_p1", 28, E_SUB, 2'd1, 4'b1000, A_SUB);
        esp("f_medio", 30, E_SUB, 2'd1, 4'b1000, A_SUB);
        paso(4'b0001, 1'b0);
        correr(3, 1'b0);
        paso(4'b0000, 1'b1);
        paso(4'b0000, 1'b1);
        paso(4'b1000, 1'b1);
        correr(7, 1'b1);
        correr(16, 1'b0);
        cerrar("e");

        // Reset between floors 1 and 2 acts without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        comprobar("f_reset_async", {21'd0, salidas}, 32'd0);
        @(posedge clk);
        #1;
        comprobar("f_reset_borde", {21'd0, salidas}, 32'd0);
        reset = 1'b0;
        ciclo = 0;
        esp("f_quieto", 3, E_REP, 2'd0, 4'b0000, A_NADA);
        correr(3, 1'b0);
        cerrar("f");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
